// File: rtl/xperiph_bus.sv
// Registered bridge from the controller data bus to N_SLV memory-mapped peripheral slots.
// Define PERIPH_BUS_TIMEOUT_EN to compile in the ACCESS watchdog (otherwise ACCESS waits forever).
module xperiph_bus #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int SLV_ADDR_W = 6,
  parameter int N_SLV      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_sel,
  input  logic                    m_we,
  input  logic [ADDR_W-1:0]       m_addr,
  input  logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_ready,
  output logic [N_SLV-1:0]        s_sel,
  output logic                    s_we,
  output logic [SLV_ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
  input  logic [N_SLV-1:0]        s_ready,
  input  logic                    err_clr,
  output logic                    err,
  output logic [ADDR_W-1:0]       err_addr
);
  localparam int IDX_W = ADDR_W - SLV_ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t                  state_q, state_d;
  logic [N_SLV-1:0]        s_sel_q, s_sel_d;
  logic                    s_we_q, s_we_d;
  logic [SLV_ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]       s_wdata_q, s_wdata_d;
  logic                    m_ready_q, m_ready_d;
  logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;
  logic                    err_q, err_d;
  logic [ADDR_W-1:0]       err_addr_q, err_addr_d;

  logic [IDX_W-1:0]        req_idx;
  logic                    req_dec_err;
  logic [N_SLV-1:0]        req_onehot;
  logic                    sel_ready;
  logic [DATA_W-1:0]       sel_rdata;
  logic [DATA_W-1:0]       rdata_masked [N_SLV];

`ifdef PERIPH_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign req_idx     = m_addr[ADDR_W-1:SLV_ADDR_W];
  assign req_dec_err = (int'(req_idx) >= N_SLV);

  // s_sel_q is one-hot during ACCESS, so it doubles as the ready/read-data mux select.
  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_slot
    assign req_onehot[gi]   = (int'(req_idx) == gi);
    assign rdata_masked[gi] = s_sel_q[gi] ? s_rdata[gi*DATA_W +: DATA_W] : '0;
  end

  assign sel_ready = |(s_ready & s_sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_SLV; k++) sel_rdata = sel_rdata | rdata_masked[k];
  end

  always_comb begin
    state_d    = state_q;
    s_sel_d    = s_sel_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    m_ready_d  = 1'b0;
    m_rdata_d  = m_rdata_q;
    err_d      = err_q & ~err_clr;
    err_addr_d = err_addr_q;
`ifdef PERIPH_BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
    addr_d     = addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (m_sel) begin
          s_we_d    = m_we;
          s_addr_d  = m_addr[SLV_ADDR_W-1:0];
          s_wdata_d = m_wdata;
`ifdef PERIPH_BUS_TIMEOUT_EN
          cnt_d     = '0;
          addr_d    = m_addr;
`endif
          if (req_dec_err) begin
            state_d    = ERR;
            m_ready_d  = 1'b1;
            err_d      = 1'b1;
            err_addr_d = m_addr;
            if (!m_we) m_rdata_d = '1;
          end else begin
            state_d = ACCESS;
            s_sel_d = req_onehot;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d   = RESP;
          m_ready_d = 1'b1;
          s_sel_d   = '0;
          if (!s_we_q) m_rdata_d = sel_rdata;
`ifdef PERIPH_BUS_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This stall cycle is the TIMEOUT-th one: abandon the slave access.
          state_d    = ERR;
          m_ready_d  = 1'b1;
          s_sel_d    = '0;
          err_d      = 1'b1;
          err_addr_d = addr_q;
          if (!s_we_q) m_rdata_d = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      s_sel_q    <= '0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      m_ready_q  <= 1'b0;
      m_rdata_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
`ifdef PERIPH_BUS_TIMEOUT_EN
      cnt_q      <= '0;
      addr_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      s_sel_q    <= s_sel_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m_ready_q  <= m_ready_d;
      m_rdata_q  <= m_rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
`ifdef PERIPH_BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
`endif
    end
  end

  assign s_sel    = s_sel_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m_ready  = m_ready_q;
  assign m_rdata  = m_rdata_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
endmodule

// File: tb/tb_xperiph_bus.sv
// Randomized transaction-level bench for xperiph_bus; expected outputs per cycle come from a timeline model.
// Watchdog scenarios run only when PERIPH_BUS_TIMEOUT_EN is defined.
module tb_xperiph_bus;
  localparam int DW = 32, AW = 12, SAW = 6, NS = 4, TO = 8;
`ifdef PERIPH_BUS_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, m_sel, m_we, m_ready, s_we, err_clr, err;
  logic [AW-1:0] m_addr, err_addr;
  logic [DW-1:0] m_wdata, m_rdata, s_wdata;
  logic [NS-1:0] s_sel, s_ready;
  logic [SAW-1:0] s_addr;
  logic [NS*DW-1:0] s_rdata;
  logic [DW-1:0] slot_data [NS];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NS; gi++) begin : g_sd
    assign s_rdata[gi*DW +: DW] = slot_data[gi];
  end

  xperiph_bus #(.DATA_W(DW), .ADDR_W(AW), .SLV_ADDR_W(SAW), .N_SLV(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_sel(m_sel), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready), .err_clr(err_clr),
    .err(err), .err_addr(err_addr)
  );

  // Model state and per-cycle expectations
  logic           mdl_err = 1'b0;
  logic [AW-1:0]  mdl_err_addr = '0;
  logic [DW-1:0]  mdl_rdata = '0;
  logic [NS-1:0]  exp_s_sel = '0;
  logic           exp_s_we = 1'b0, exp_m_ready = 1'b0, chk_bus = 1'b0, chk_en = 1'b0;
  logic [SAW-1:0] exp_s_addr = '0;
  logic [DW-1:0]  exp_s_wdata = '0;
  logic           force_en = 1'b0;
  logic [DW-1:0]  force_val = '0;
  int n_cmp = 0, n_bad = 0, n_txn = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      cmp("m_ready", 64'(m_ready), 64'(exp_m_ready));
      cmp("m_rdata", 64'(m_rdata), 64'(mdl_rdata));
      cmp("err", 64'(err), 64'(mdl_err));
      cmp("err_addr", 64'(err_addr), 64'(mdl_err_addr));
      cmp("s_sel", 64'(s_sel), 64'(exp_s_sel));
      if (chk_bus) begin
        cmp("s_we", 64'(s_we), 64'(exp_s_we));
        cmp("s_addr", 64'(s_addr), 64'(exp_s_addr));
        cmp("s_wdata", 64'(s_wdata), 64'(exp_s_wdata));
      end
    end
  end

  // One idle cycle: no request; err_clr random unless forced.
  task automatic idle_step(input bit force_clr);
    @(negedge clk);
    rst = 1'b1;
    m_sel = 1'b0;
    m_we = 1'($urandom);
    m_addr = AW'($urandom);
    m_wdata = $urandom;
    s_ready = NS'($urandom);
    err_clr = force_clr | ($urandom_range(0, 7) == 0);
    if (err_clr) mdl_err = 1'b0;
    exp_m_ready = 1'b0;
    exp_s_sel = '0;
    chk_bus = 1'b0;
  endtask

  // One request; d = wait cycles before the slot raises s_ready; rst_at = edge index to pulse reset (-1: none).
  task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int d, input bit clr_at_set, input int rst_at);
    int idx, acc, last, set_edge;
    bit derr, tmo, clr;
    logic [NS-1:0] oh;
    idx = int'(addr[AW-1:SAW]);
    derr = (idx >= NS);
    oh = derr ? '0 : (NS'(1) << idx);
    tmo = !derr && WD_EN && (d >= TO);
    acc = derr ? 0 : (tmo ? TO : d + 1);
    last = derr ? 1 : acc + 1;
    set_edge = derr ? 0 : (tmo ? acc : -1);
    $display("txn %0d we=%0b addr=%h wdata=%h wait=%0d", n_txn, we, addr, wdata, d);
    n_txn++;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      rst = 1'b1;
      if (c == 0) begin
        for (int k = 0; k < NS; k++) slot_data[k] = $urandom;
        if (force_en && !derr) slot_data[idx] = force_val;
        m_sel = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
      end else begin
        m_sel = 1'($urandom); m_we = 1'($urandom); m_addr = AW'($urandom); m_wdata = $urandom;
      end
      s_ready = NS'($urandom) & ~oh;
      if (!derr && c >= 1 && c <= acc && c == d + 1) s_ready = s_ready | oh;
      clr = (clr_at_set && c == set_edge) || ($urandom_range(0, 7) == 0);
      err_clr = clr;
      if (c == rst_at) begin
        rst = 1'b0;
        mdl_err = 1'b0; mdl_err_addr = '0; mdl_rdata = '0;
        exp_m_ready = 1'b0; exp_s_sel = '0; chk_bus = 1'b1;
        exp_s_we = 1'b0; exp_s_addr = '0; exp_s_wdata = '0;
        break;
      end
      if (c == set_edge) begin
        mdl_err = 1'b1;
        mdl_err_addr = addr;
      end else if (clr) mdl_err = 1'b0;
      if (!derr && c < acc) begin
        exp_m_ready = 1'b0; exp_s_sel = oh; chk_bus = 1'b1;
        exp_s_we = we; exp_s_addr = addr[SAW-1:0]; exp_s_wdata = wdata;
      end else if (c == (derr ? 0 : acc)) begin
        exp_m_ready = 1'b1; exp_s_sel = '0; chk_bus = 1'b0;
        if (!we) mdl_rdata = (derr || tmo) ? '1 : slot_data[idx];
      end else begin
        exp_m_ready = 1'b0; exp_s_sel = '0; chk_bus = 1'b0;
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  logic [DW-1:0] saved;
  logic [AW-1:0] ra;
  int rd, gap;

  initial begin
    rst = 1'b0; m_sel = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_ready = '0; err_clr = 1'b0;
    for (int k = 0; k < NS; k++) slot_data[k] = '0;
    @(negedge clk);
    chk_en = 1'b1; chk_bus = 1'b1;
    repeat (2) idle_step(1'b0);

    // Zero-wait read from slot 2
    force_en = 1'b1; force_val = 32'h1234_5678;
    run_txn(1'b0, 12'h085, 32'h0, 0, 1'b0, -1);
    force_en = 1'b0;
    settle();
    cmp("lit_rdata_slot2", 64'(m_rdata), 64'h1234_5678);
    idle_step(1'b0);

    // Write to slot 1 with three wait states
    saved = m_rdata;
    run_txn(1'b1, 12'h040, 32'hA5, 3, 1'b0, -1);
    settle();
    cmp("lit_rdata_after_write", 64'(m_rdata), 64'(saved));

    // Decode error read, then clear
    run_txn(1'b0, 12'h140, 32'h0, 0, 1'b0, -1);
    settle();
    cmp("lit_err_set", 64'(err), 64'h1);
    cmp("lit_err_addr", 64'(err_addr), 64'h140);
    cmp("lit_err_rdata", 64'(m_rdata), 64'hFFFF_FFFF);
    idle_step(1'b1);
    settle();
    cmp("lit_err_cleared", 64'(err), 64'h0);

    // err_clr coincident with an error set
    run_txn(1'b1, 12'hFC0, 32'h1, 0, 1'b1, -1);
    settle();
    cmp("lit_set_beats_clr", 64'(err), 64'h1);
    idle_step(1'b1);

    if (WD_EN) begin
      run_txn(1'b0, 12'h003, 32'h0, 20, 1'b0, -1);
      settle();
      cmp("lit_wd_err", 64'(err), 64'h1);
      cmp("lit_wd_rdata", 64'(m_rdata), 64'hFFFF_FFFF);
      idle_step(1'b1);
      force_en = 1'b1; force_val = 32'hCAFE_0008;
      run_txn(1'b0, 12'h003, 32'h0, TO - 1, 1'b0, -1);
      force_en = 1'b0;
      settle();
      cmp("lit_wd_race_err", 64'(err), 64'h0);
      cmp("lit_wd_race_rdata", 64'(m_rdata), 64'hCAFE_0008);
    end

    // Reset during a wait, then a normal request
    run_txn(1'b0, 12'h0C1, 32'h0, 5, 1'b0, 2);
    settle();
    cmp("lit_rst_rdata", 64'(m_rdata), 64'h0);
    cmp("lit_rst_sel", 64'(s_sel), 64'h0);
    idle_step(1'b0);
    run_txn(1'b0, 12'h0C1, 32'h0, 1, 1'b0, -1);

    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) idle_step(1'b0);
      if ($urandom_range(0, 3) != 0) ra = {6'($urandom_range(0, NS - 1)), 6'($urandom)};
      else ra = {6'($urandom_range(NS, 63)), 6'($urandom)};
      rd = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 11) : $urandom_range(0, 3);
      run_txn(1'($urandom), ra, $urandom, rd, ($urandom_range(0, 3) == 0), -1);
    end
    idle_step(1'b0);
    idle_step(1'b0);
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/xperiph_bus.md
# xperiph_bus

Parametrised peripheral bus bridge between the controller data bus and up to N_SLV memory-mapped peripheral slots, such as the score display, object display, paddle and start registers. It replaces fixed, zero-wait, combinational peripheral decoding with a registered transaction engine. The engine provides per-slot ready handshakes (wait states), decode-error detection, and an optional access watchdog. It sits between the controller's data port and the user peripherals inside the top level.

## Interface
Parameters:
- DATA_W, 32, data width of master and slave buses
- ADDR_W, 12, master address width
- SLV_ADDR_W, 6, address bits forwarded to each slot; slot window = 2**SLV_ADDR_W words
- N_SLV, 4, number of slots (1..2**(ADDR_W-SLV_ADDR_W))
- TIMEOUT, 255, maximum cycles in ACCESS before watchdog error (1..65535)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-low reset
- m_sel  in  1  master request
- m_we  in  1  master write (1) / read (0)
- m_addr  in  ADDR_W  master word address
- m_wdata  in  DATA_W  master write data
- m_rdata  out  DATA_W  read data, valid when m_ready=1 on a read
- m_ready  out  1  one-cycle completion pulse
- s_sel  out  N_SLV  one-hot slot select
- s_we  out  1  slot write strobe qualifier
- s_addr  out  SLV_ADDR_W  slot-local address
- s_wdata  out  DATA_W  slot write data
- s_rdata  in  N_SLV*DATA_W  flattened slot read data; slot k at [k*DATA_W +: DATA_W]
- s_ready  in  N_SLV  slot completion, combinational allowed
- err_clr  in  1  clears sticky error
- err  out  1  sticky error flag
- err_addr  out  ADDR_W  address of the most recent failed access

## Operation
- Slot index = m_addr[ADDR_W-1:SLV_ADDR_W]. An index ≥ N_SLV is a decode error.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE: if m_sel=1, latch m_we, m_addr and m_wdata into internal registers. Go to ERR on a decode error, otherwise go to ACCESS.
- ACCESS: drive s_sel[slot]=1 with the latched s_we, s_addr and s_wdata. All other s_sel bits are 0.
  - If s_ready[slot]=1 on a read, capture s_rdata[slot] into m_rdata. On either read or write, go to RESP.
  - s_ready bits of unselected slots are ignored.
- RESP: m_ready=1 for exactly one cycle, s_sel=0, then go to IDLE.
- ERR: m_ready=1 for exactly one cycle. If the access was a read, m_rdata = {DATA_W{1'b1}}. Set err=1, load err_addr with the latched address, then go to IDLE.
- m_sel is ignored outside IDLE. Master inputs may change after the IDLE sample without effect.
- m_rdata changes only on read completions and error reads; write completions leave it unchanged.
- err_clr=1 clears err. If err_clr and a new error-set occur in the same cycle, the set wins. err_addr is never cleared except by reset.
- Watchdog (when compiled in): a cycle counter is zeroed on entry to ACCESS and increments each ACCESS cycle without s_ready.
  - When the count reaches TIMEOUT, go to ERR: s_sel drops and the slave access is abandoned.
  - s_ready arriving in the same cycle as the timeout takes priority, giving normal completion.
- Counter width = clog2(TIMEOUT+1).

## Timing
- Reset (rst=0 at an edge): state=IDLE; s_sel=0, s_we=0, s_addr=0, s_wdata=0, m_ready=0, m_rdata=0, err=0, err_addr=0, counter=0. A reset during ACCESS abandons the transfer with no m_ready pulse.
- Zero-wait latency: m_sel sampled at edge 0, s_sel high during cycle 1, m_ready high during cycle 2.
- Each s_ready-low cycle adds 1 cycle of latency.
- Decode error: m_ready in cycle 1 (ERR), no slot selected.
- Back-to-back rate: one request per 3 cycles. A new request is accepted in the IDLE cycle after RESP/ERR.
- All outputs are registered; no combinational path from m_* to s_* or to m_ready.

## Configuration
- PERIPH_BUS_TIMEOUT_EN defined: the watchdog counter and timeout transition are present as described above.
- PERIPH_BUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for s_ready. err is set only by decode errors. The TIMEOUT parameter is unused.

## Test plan
- Zero-wait read, slot 2 with s_rdata = 0x12345678 and s_ready tied to 1, m_addr=0x085 → s_sel=4'b0100 and s_addr=0x05 in cycle 1; m_ready=1 and m_rdata=0x12345678 in cycle 2.
- Write to slot 1 with s_ready delayed 3 cycles, m_wdata=0xA5 → s_sel=4'b0010 held for 4 cycles; single m_ready pulse afterwards; m_rdata unchanged.
- Decode error, m_addr=0x140 (index 5) with N_SLV=4 → no s_sel; m_ready in cycle 1; read returns 0xFFFFFFFF; err=1, err_addr=0x140. Then pulse err_clr → err=0.
- Watchdog with TIMEOUT=8, slot 0 never ready → s_sel high 8 cycles then drops; m_ready with 0xFFFFFFFF; err=1.
  - Variant: s_ready asserted exactly on the 8th cycle → normal completion, err stays 0.
- Reset mid-ACCESS, rst=0 for 1 cycle during a wait → all outputs zero next cycle, no m_ready. A following request completes normally.
- Simultaneous err_clr=1 and a decode error entering ERR → err remains 1.
